// File: rtl/alien_sprite_engine_if.sv
// alien_sprite_engine_if: sprite ROM bus, row/col address out and colour word back one clk later.
interface alien_sprite_engine_if;
  logic [2:0]  rom_row;
  logic [3:0]  rom_col;
  logic [11:0] rom_data;
  modport master (output rom_row, rom_col, input rom_data);
  modport slave (input rom_row, rom_col, output rom_data);
endinterface

// File: rtl/alien_sprite_engine.sv
// alien_sprite_engine: one alien's march/step-down/life state plus a 2-stage ROM-aligned pixel output.
// Define ALIEN_HIT_FLASH_EN to add a red-flash DYING phase of 8 frames before DEAD.
module alien_sprite_engine #(
  parameter int X_START     = 100,
  parameter int Y_START     = 40,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int Y_LAND      = 440,
  parameter int STEP_X      = 2,
  parameter int STEP_Y      = 8,
  parameter int MOVE_DIV    = 4,
  parameter int SCALE_SHIFT = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         video_on,
  input  logic [9:0]                   pixel_x,
  input  logic [9:0]                   pixel_y,
  input  logic                         refresh_tick,
  input  logic                         hit,
  input  logic                         restart,
  alien_sprite_engine_if.master        rom,
  output logic                         alien_on,
  output logic [11:0]                  rgb_out,
  output logic [9:0]                   alien_x,
  output logic [9:0]                   alien_y,
  output logic                         alive,
  output logic                         landed
);
  localparam logic [11:0] W = 12'(11 << SCALE_SHIFT);
  localparam logic [11:0] H = 12'(8 << SCALE_SHIFT);
  localparam int CW = MOVE_DIV > 8 ? $clog2(MOVE_DIV) : 3;
  typedef enum logic [2:0] {
    MOVE_R,
    MOVE_L,
`ifdef ALIEN_HIT_FLASH_EN
    DYING,
`endif
    DEAD,
    LANDED
  } state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [11:0]   xw, yw, px, py, dx, dy, y_down;
  logic          in_region, stage0_on, opaque, moving, step, edge_r, edge_l, flash, pix_on;
  assign xw = {2'b0, alien_x};
  assign yw = {2'b0, alien_y};
  assign px = {2'b0, pixel_x};
  assign py = {2'b0, pixel_y};
  assign dx = px - xw;
  assign dy = py - yw;
  assign in_region = px >= xw && px < xw + W && py >= yw && py < yw + H;
  assign rom.rom_col = in_region ? 4'(dx >> SCALE_SHIFT) : 4'd0;
  assign rom.rom_row = in_region ? 3'(dy >> SCALE_SHIFT) : 3'd0;
  assign opaque = rom.rom_data != 12'hFFF;
  assign moving = state == MOVE_R || state == MOVE_L;
  assign step = refresh_tick && moving && cnt == CW'(MOVE_DIV - 1);
  assign edge_r = xw + W + 12'(STEP_X) > 12'(X_MAX + 1);
  assign edge_l = xw < 12'(X_MIN + STEP_X);
  assign y_down = yw + 12'(STEP_Y);
  assign pix_on = stage0_on && opaque && state != DEAD;
`ifdef ALIEN_HIT_FLASH_EN
  assign flash = state == DYING;
`else
  assign flash = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= MOVE_R;
      alien_x   <= 10'(X_START);
      alien_y   <= 10'(Y_START);
      cnt       <= '0;
      alive     <= 1'b1;
      landed    <= 1'b0;
      stage0_on <= 1'b0;
      alien_on  <= 1'b0;
      rgb_out   <= 12'h000;
    end else begin
      stage0_on <= in_region && video_on;
      alien_on  <= pix_on;
      rgb_out   <= pix_on ? (flash ? 12'hF00 : rom.rom_data) : 12'h000;
      if (restart) begin
        state   <= MOVE_R;
        alien_x <= 10'(X_START);
        alien_y <= 10'(Y_START);
        cnt     <= '0;
        alive   <= 1'b1;
        landed  <= 1'b0;
      end else if (hit && (moving || state == LANDED)) begin
        landed <= 1'b0;
`ifdef ALIEN_HIT_FLASH_EN
        state  <= DYING;
        cnt    <= '0;
`else
        state  <= DEAD;
        alive  <= 1'b0;
`endif
      end else if (refresh_tick && moving) begin
        cnt <= step ? '0 : cnt + 1'b1;
        if (step) begin
          if (state == MOVE_R && !edge_r) alien_x <= alien_x + 10'(STEP_X);
          else if (state == MOVE_L && !edge_l) alien_x <= alien_x - 10'(STEP_X);
          else begin
            alien_y <= 10'(y_down);
            landed  <= y_down + H >= 12'(Y_LAND);
            state   <= y_down + H >= 12'(Y_LAND) ? LANDED : (state == MOVE_R ? MOVE_L : MOVE_R);
          end
        end
      end
`ifdef ALIEN_HIT_FLASH_EN
      else if (refresh_tick && state == DYING) begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(7)) begin
          state <= DEAD;
          alive <= 1'b0;
        end
      end
`endif
    end
endmodule
